// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 8-digit multiplexed seven-segment scanner with dead-time blanking and hex decode.
// Optional blink masking is built only when SEG_BLINK_EN is defined.
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 12500,
    parameter int BLANK_CYC = 8,
    parameter int BLINK_DIV = 250
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] digits,
    input  logic [7:0]  blank_mask,
    input  logic [7:0]  dp_mask,
    input  logic [7:0]  blink_mask,
    output logic [7:0]  anode,
    output logic [6:0]  seg,
    output logic        dp,
    output logic        frame_start
);
    localparam int CW = $clog2(SCAN_DIV);
    typedef enum logic {BLANK, SHOW} state_t;
    state_t      state;
    logic [2:0]  idx;
    logic [CW-1:0] cnt;
    logic [31:0] sh_digits;
    logic [7:0]  sh_blank, sh_dp;
    logic        blank_end, show_end, frame, phase_n, on;
    logic [31:0] d_n;
    logic [7:0]  b_n, p_n, k_n;
    logic [3:0]  nib;
    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'ha: hex7 = 7'b0001000;
            4'hb: hex7 = 7'b0000011;
            4'hc: hex7 = 7'b1000110;
            4'hd: hex7 = 7'b0100001;
            4'he: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction
    assign blank_end = (state == BLANK) && (cnt == CW'(BLANK_CYC - 1));
    assign show_end  = (state == SHOW) && (cnt == CW'(SCAN_DIV - BLANK_CYC - 1));
    assign frame     = blank_end && (idx == 3'd0);
    // On the frame edge the shadows load on the same clock, so decode from the live inputs
    assign d_n = frame ? digits : sh_digits;
    assign b_n = frame ? blank_mask : sh_blank;
    assign p_n = frame ? dp_mask : sh_dp;
    assign nib = d_n[4*idx +: 4];
    assign on  = ~b_n[idx] & ~(phase_n & k_n[idx]);
`ifdef SEG_BLINK_EN
    localparam int FW = $clog2(BLINK_DIV + 1);
    logic [FW-1:0] fcnt;
    logic          phase;
    logic [7:0]    sh_blink;
    assign k_n     = frame ? blink_mask : sh_blink;
    assign phase_n = (frame && fcnt == FW'(BLINK_DIV)) ? ~phase : phase;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fcnt     <= '0;
            phase    <= 1'b0;
            sh_blink <= '0;
        end else if (frame) begin
            fcnt     <= (fcnt == FW'(BLINK_DIV)) ? FW'(1) : fcnt + FW'(1);
            phase    <= phase_n;
            sh_blink <= blink_mask;
        end
    end
`else
    logic unused_blink;
    assign unused_blink = ^blink_mask ^ (BLINK_DIV == 0);
    assign k_n     = 8'h00;
    assign phase_n = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BLANK;
            idx         <= '0;
            cnt         <= '0;
            sh_digits   <= '0;
            sh_blank    <= '0;
            sh_dp       <= '0;
            anode       <= 8'hFF;
            seg         <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame;
            if (frame) begin
                sh_digits <= digits;
                sh_blank  <= blank_mask;
                sh_dp     <= dp_mask;
            end
            if (blank_end) begin
                state <= SHOW;
                cnt   <= '0;
                anode <= on ? ~(8'h01 << idx) : 8'hFF;
                seg   <= hex7(nib);
                dp    <= ~(on & p_n[idx]);
            end else if (show_end) begin
                state <= BLANK;
                cnt   <= '0;
                idx   <= idx + 3'd1;
                anode <= 8'hFF;
                seg   <= 7'h7F;
                dp    <= 1'b1;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: scoreboard bench for seg_scan_ctrl; per-digit expectations queued when frame inputs are driven.
module tb_seg_scan_ctrl;
    localparam int SD = 10, BC = 2, BD = 2;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] digits;
    logic [7:0]  blank_mask, dp_mask, blink_mask;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        dp, frame_start;
    int tests = 0, fails = 0;
    typedef struct packed {logic [7:0] an; logic [6:0] sg; logic d;} exp_t;
    exp_t q[$];
    logic [6:0]  hexlut[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [31:0] tdig[8] = '{32'h76543210, 32'h88888888, 32'h89ABCDEF, 32'h76543210,
                             32'h0123ABCD, 32'hFFFF0000, 32'h76543210, 32'hFEDCBA98};
    logic [7:0]  tblank[8] = '{8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h80, 8'h00, 8'h42};
    logic [7:0]  tdp[8]    = '{8'h00, 8'h00, 8'h80, 8'h0F, 8'h55, 8'h00, 8'h00, 8'h81};
    logic [7:0]  tblink[8] = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01};

    seg_scan_ctrl #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
        .clk(clk), .rst(rst), .digits(digits), .blank_mask(blank_mask), .dp_mask(dp_mask),
        .blink_mask(blink_mask), .anode(anode), .seg(seg), .dp(dp), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic dark_phase(input int n);
`ifdef SEG_BLINK_EN
        return ((n - 1) / BD) % 2 == 1;
`else
        return n < 0;
`endif
    endfunction

    // Drive inputs of table row t (frame number n, 1-based since reset) and queue its 8 digits
    task automatic drive_frame(input int t, input int n);
        logic lit;
        digits = tdig[t]; blank_mask = tblank[t]; dp_mask = tdp[t]; blink_mask = tblink[t];
        for (int i = 0; i < 8; i++) begin
            lit = !tblank[t][i] && !(dark_phase(n) && tblink[t][i]);
            q.push_back('{lit ? ~(8'h01 << i) : 8'hFF, hexlut[tdig[t][4*i +: 4]], lit ? ~tdp[t][i] : 1'b1});
        end
    endtask

    task automatic run_seq(input int first, input int nfr, input int stop);
        exp_t cur, ex;
        int s, dg, f;
        cur = '{8'hFF, 7'h7F, 1'b1};
        for (int k = 1; k <= stop; k++) begin
            @(posedge clk); #1;
            s = (k >= 2) ? (k - 2) % SD : SD - 1;
            dg = (k >= 2) ? ((k - 2) / SD) % 8 : 0;
            f = (k >= 2) ? (k - 2) / (8 * SD) : 0;
            if (k >= 2 && s == 0) begin
                check("queue_nonempty", 32'(q.size() != 0), 1);
                cur = (q.size() != 0) ? q.pop_front() : '{8'hFF, 7'h7F, 1'b1};
            end
            ex = (s >= SD - BC) ? '{8'hFF, 7'h7F, 1'b1} : cur;
            check("anode", 32'(anode), 32'(ex.an));
            check("seg", 32'(seg), 32'(ex.sg));
            check("dp", 32'(dp), 32'(ex.d));
            check("frame_start", 32'(frame_start), 32'(k >= 2 && (k - 2) % (8 * SD) == 0));
            if (k >= 2 && dg == 3 && s == 3 && f + 1 < nfr)
                drive_frame(first + f + 1, f + 2);
        end
    endtask

    initial begin
        rst = 1'b1;
        digits = '0; blank_mask = '0; dp_mask = '0; blink_mask = '0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_anode", 32'(anode), 32'hFF);
        check("rst_seg", 32'(seg), 32'h7F);
        check("rst_dp", 32'(dp), 1);
        check("rst_frame_start", 32'(frame_start), 0);
        drive_frame(0, 1);
        @(negedge clk) rst = 1'b0;
        // Stop mid digit-5 SHOW of frame 6 and hit reset between edges
        run_seq(0, 6, 2 + 5 * 8 * SD + 5 * SD + 3);
        #3 rst = 1'b1;
        #1;
        check("async_anode", 32'(anode), 32'hFF);
        check("async_seg", 32'(seg), 32'h7F);
        check("async_dp", 32'(dp), 1);
        check("async_frame_start", 32'(frame_start), 0);
        q.delete();
        drive_frame(6, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        run_seq(6, 2, 1 + 2 * 8 * SD);
        check("queue_drained", 32'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
